// File: rtl/version_store_ctrl_if.sv
// Write, read-request and read-response channels of the versioned store.
// Each channel completes a transfer on the rising edge where valid && ready.
interface version_store_ctrl_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4
);
    logic                     wrValid;
    logic                     wrReady;
    logic [VERSION_WIDTH-1:0] wrVersion;
    logic [DATA_WIDTH-1:0]    wrData;
    logic                     rdValid;
    logic                     rdReady;
    logic [VERSION_WIDTH-1:0] rdVersion;
    logic                     respValid;
    logic                     respReady;
    logic                     respHit;
    logic [VERSION_WIDTH-1:0] respVersion;
    logic [DATA_WIDTH-1:0]    respData;

    modport master (
        output wrValid, wrVersion, wrData, rdValid, rdVersion, respReady,
        input  wrReady, rdReady, respValid, respHit, respVersion, respData
    );

    modport slave (
        input  wrValid, wrVersion, wrData, rdValid, rdVersion, respReady,
        output wrReady, rdReady, respValid, respHit, respVersion, respData
    );
endinterface

// File: rtl/version_store_ctrl.sv
// Versioned slot bank: accepts versioned writes and answers "newest version
// strictly below X" reads with a one-slot-per-cycle scan over a frozen bank.
module version_store_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    version_store_ctrl_if.slave                bus,
    output logic [$clog2(VERSION_NUM+1)-1:0]   o_count,
    output logic [1:0]                         o_state
);
    localparam int IW = $clog2(VERSION_NUM);
    localparam int CW = $clog2(VERSION_NUM + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [VERSION_NUM-1:0]   r_valid;
    logic [VERSION_WIDTH-1:0] r_ver  [VERSION_NUM];
    logic [DATA_WIDTH-1:0]    r_data [VERSION_NUM];
    logic [CW-1:0]            r_count;

    logic [VERSION_WIDTH-1:0] r_limit;
    logic [IW-1:0]            r_idx;
    logic                     r_best_hit;
    logic [VERSION_WIDTH-1:0] r_best_ver;
    logic [IW-1:0]            r_best_idx;
    logic                     r_resp_hit;
    logic [VERSION_WIDTH-1:0] r_resp_ver;
    logic [DATA_WIDTH-1:0]    r_resp_data;

    logic                     w_wr_fire;
    logic                     w_rd_fire;
    logic                     w_scan_last;
    logic                     w_take;
    logic                     w_nb_hit;
    logic [VERSION_WIDTH-1:0] w_nb_ver;
    logic [IW-1:0]            w_nb_idx;
    logic                     w_match_found;
    logic [IW-1:0]            w_match_idx;
    logic                     w_free_found;
    logic [IW-1:0]            w_free_idx;
    logic [IW-1:0]            w_victim_idx;
    logic [VERSION_WIDTH-1:0] w_victim_ver;
    logic [IW-1:0]            w_wr_idx;
    logic                     w_wr_new;

    // Readies are forced low during reset so nothing is advertised mid-reset.
    assign bus.wrReady     = (r_state == S_IDLE) && !rst;
    assign bus.rdReady     = (r_state == S_IDLE) && !rst && !bus.wrValid;
    assign bus.respValid   = (r_state == S_RESP);
    assign bus.respHit     = r_resp_hit;
    assign bus.respVersion = r_resp_ver;
    assign bus.respData    = r_resp_data;
    assign o_count         = r_count;
    assign o_state         = r_state;

    assign w_wr_fire   = bus.wrValid && bus.wrReady;
    assign w_rd_fire   = bus.rdValid && bus.rdReady;
    assign w_scan_last = (r_idx == IW'(VERSION_NUM - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_rd_fire)     w_next_state = S_SCAN;
            S_SCAN:  if (w_scan_last)   w_next_state = S_RESP;
            S_RESP:  if (bus.respReady) w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    // Victim search assumes a full bank; it is only used when no slot is free.
    always_comb begin
        w_match_found = 1'b0;
        w_match_idx   = '0;
        w_free_found  = 1'b0;
        w_free_idx    = '0;
        w_victim_idx  = '0;
        w_victim_ver  = r_ver[0];
        for (int i = 0; i < VERSION_NUM; i++) begin
            if (!w_match_found && r_valid[i] && (r_ver[i] == bus.wrVersion)) begin
                w_match_found = 1'b1;
                w_match_idx   = IW'(i);
            end
            if (!w_free_found && !r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
            if (r_ver[i] < w_victim_ver) begin
                w_victim_ver = r_ver[i];
                w_victim_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_wr_new = !w_match_found && w_free_found;
        if (w_match_found)     w_wr_idx = w_match_idx;
        else if (w_free_found) w_wr_idx = w_free_idx;
        else                   w_wr_idx = w_victim_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < VERSION_NUM; i++) begin
                r_ver[i]  <= '0;
                r_data[i] <= '0;
            end
        end else if (w_wr_fire) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_ver[w_wr_idx]   <= bus.wrVersion;
            r_data[w_wr_idx]  <= bus.wrData;
            if (w_wr_new) r_count <= r_count + CW'(1);
        end
    end

    // Best-so-far including the slot under the scan pointer this cycle.
    always_comb begin
        w_take   = r_valid[r_idx] && (r_ver[r_idx] < r_limit) &&
                   (!r_best_hit || (r_ver[r_idx] > r_best_ver));
        w_nb_hit = r_best_hit;
        w_nb_ver = r_best_ver;
        w_nb_idx = r_best_idx;
        if (w_take) begin
            w_nb_hit = 1'b1;
            w_nb_ver = r_ver[r_idx];
            w_nb_idx = r_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_limit     <= '0;
            r_idx       <= '0;
            r_best_hit  <= 1'b0;
            r_best_ver  <= '0;
            r_best_idx  <= '0;
            r_resp_hit  <= 1'b0;
            r_resp_ver  <= '0;
            r_resp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_fire) begin
                        r_limit    <= bus.rdVersion;
                        r_idx      <= '0;
                        r_best_hit <= 1'b0;
                        r_best_ver <= '0;
                        r_best_idx <= '0;
                    end
                end
                S_SCAN: begin
                    r_best_hit <= w_nb_hit;
                    r_best_ver <= w_nb_ver;
                    r_best_idx <= w_nb_idx;
                    r_idx      <= r_idx + IW'(1);
                    if (w_scan_last) begin
                        r_resp_hit  <= w_nb_hit;
                        r_resp_ver  <= w_nb_hit ? w_nb_ver : '0;
                        r_resp_data <= w_nb_hit ? r_data[w_nb_idx] : '0;
                    end
                end
                S_RESP: begin
                    if (bus.respReady) begin
                        r_resp_hit  <= 1'b0;
                        r_resp_ver  <= '0;
                        r_resp_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
